glyph_rain_sequencer: RTL

Digital-rain scan sequencer sitting directly upstream of the glyph ROM. It consumes the VGA timing generator's beam position and keeps per-column "drop" state updated once per frame. For every pixel it produces the ROM address: glyph index, glyph row and glyph column. It also produces a 2-bit intensity, which the colour stage applies to the ROM's pixel bit. The screen is 40×20 cells of 16×24 screen pixels, each cell an 8×12 glyph at 2× scale.

---
 rtl/glyph_pkg.sv | 23 ++
 rtl/rain_column_bank.sv | 68 ++++++
 rtl/glyph_rain_sequencer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/glyph_pkg.sv
// Shared constants for the digital-rain glyph pipeline: glyph geometry, LFSR
// parameters, intensity encoding and the sequencer state type.
package glyph_pkg;
  localparam int GLYPH_W = 8;
  localparam int GLYPH_H = 12;
  localparam int SCALE   = 2;
  localparam logic [5:0] GLYPH_COUNT = 6'd48;
  localparam logic [5:0] BLANK_GLYPH = 6'd47;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam logic [1:0] INT_OFF   = 2'd0;
  localparam logic [1:0] INT_TRAIL = 2'd1;
  localparam logic [1:0] INT_NEAR  = 2'd2;
  localparam logic [1:0] INT_HEAD  = 2'd3;

  typedef enum logic {ST_IDLE, ST_UPDATE} seq_state_t;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction
endpackage

// File: rtl/rain_column_bank.sv
// Per-column drop state (head row, speed) with one render read port and one
// read-modify-write update port that advances or respawns a column.
module rain_column_bank
  import glyph_pkg::*;
#(
  parameter int COLS  = 40,
  parameter int ROWS  = 20,
  parameter int TRAIL = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] rd_col,
  output logic [4:0] rd_head,
  input  logic       upd_en,
  input  logic [5:0] upd_idx,
  input  logic [9:0] frame_cnt,
  input  logic [2:0] rnd
);
  localparam logic [4:0] HEAD_OFF   = 5'd31;
  localparam logic [4:0] RESPAWN_AT = 5'(ROWS + TRAIL - 1);
  localparam logic [5:0] COLS_N     = 6'(COLS);

  logic [4:0] head  [COLS];
  logic [1:0] speed [COLS];
  logic [4:0] cur_head, nxt_head;
  logic [1:0] cur_speed, nxt_speed;
  logic [2:0] mask;
  logic       due;

  assign rd_head = (rd_col < COLS_N) ? head[rd_col] : HEAD_OFF;

  // A column of speed s only moves on frames that are multiples of 2^s.
  always_comb begin
    cur_head  = head[upd_idx];
    cur_speed = speed[upd_idx];
    case (cur_speed)
      2'd0:    mask = 3'b000;
      2'd1:    mask = 3'b001;
      2'd2:    mask = 3'b011;
      default: mask = 3'b111;
    endcase
    due       = (frame_cnt[2:0] & mask) == 3'b000;
    nxt_head  = cur_head;
    nxt_speed = cur_speed;
    if (due) begin
      if (cur_head >= RESPAWN_AT) begin
        if (rnd[2]) begin
          nxt_head  = 5'd0;
          nxt_speed = rnd[1:0];
        end
      end else begin
        nxt_head = cur_head + 5'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < COLS; k++) begin
        head[k]  <= HEAD_OFF;
        speed[k] <= 2'd0;
      end
    end else if (upd_en) begin
      head[upd_idx]  <= nxt_head;
      speed[upd_idx] <= nxt_speed;
    end
  end
endmodule

// File: rtl/glyph_rain_sequencer.sv
// Digital-rain scan sequencer: tracks the character cell under the beam, walks
// the column bank once per frame, and registers the glyph ROM address and intensity.
module glyph_rain_sequencer
  import glyph_pkg::*;
#(
  parameter int COLS  = 40,
  parameter int ROWS  = 20,
  parameter int TRAIL = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic       display_on,
  input  logic       frame_tick,
  output logic [5:0] glyph_c,
  output logic [3:0] glyph_y,
  output logic [2:0] glyph_x,
  output logic [1:0] intensity,
  output logic       pix_valid
);
  localparam int                CELL_H   = GLYPH_H * SCALE;
  localparam logic [5:0]        COLS_N   = 6'(COLS);
  localparam logic signed [5:0] TRAIL_M1 = 6'(TRAIL - 1);

  seq_state_t  state;
  logic [5:0]  idx;
  logic [9:0]  frame_cnt;
  logic [15:0] lfsr;
  logic [4:0]  sub_cnt, row_cnt;

  logic [4:0]        sub_p0, row_p0, head_p0;
  logic [5:0]        col_p0, e_p0;
  logic signed [5:0] d_p0;
  logic [1:0]        shade_p0;

  function automatic logic [1:0] shade(input logic signed [5:0] d);
    if (d == 6'sd0)                        return INT_HEAD;
    else if (d >= 6'sd1 && d <= 6'sd3)     return INT_NEAR;
    else if (d >= 6'sd4 && d <= TRAIL_M1)  return INT_TRAIL;
    else                                   return INT_OFF;
  endfunction

  function automatic logic [5:0] glyph_of(input logic [5:0] col, input logic [4:0] row,
                                          input logic [5:0] e);
    logic [5:0] h;
    h = (col * 6'd5) ^ ({1'b0, row} * 6'd3) ^ e;
    return (h >= GLYPH_COUNT) ? h - 6'd16 : h;
  endfunction

  rain_column_bank #(.COLS(COLS), .ROWS(ROWS), .TRAIL(TRAIL)) u_bank (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_col    (col_p0),
    .rd_head   (head_p0),
    .upd_en    (state == ST_UPDATE),
    .upd_idx   (idx),
    .frame_cnt (frame_cnt),
    .rnd       (lfsr[2:0])
  );

  // Stage p0: the line start pixel already sees the advanced row/sub values.
  always_comb begin
    sub_p0 = sub_cnt;
    row_p0 = row_cnt;
    if (hpos == 10'd0) begin
      if (vpos == 10'd0) begin
        sub_p0 = 5'd0;
        row_p0 = 5'd0;
      end else if (sub_cnt == 5'(CELL_H - 1)) begin
        sub_p0 = 5'd0;
        row_p0 = row_cnt + 5'd1;
      end else begin
        sub_p0 = sub_cnt + 5'd1;
      end
    end
    col_p0   = hpos[9:4];
    d_p0     = $signed({1'b0, head_p0}) - $signed({1'b0, row_p0});
    shade_p0 = shade(d_p0);
    e_p0     = (d_p0 == 6'sd0) ? frame_cnt[7:2] : frame_cnt[9:4];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_cnt <= 5'd0;
      row_cnt <= 5'd0;
    end else begin
      sub_cnt <= sub_p0;
      row_cnt <= row_p0;
    end
  end

  // Frame walk: one column per cycle, extra ticks during the walk are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      idx       <= 6'd0;
      frame_cnt <= 10'd0;
      lfsr      <= LFSR_SEED;
    end else begin
      case (state)
        ST_IDLE: begin
          if (frame_tick) begin
            state     <= ST_UPDATE;
            idx       <= 6'd0;
            frame_cnt <= frame_cnt + 10'd1;
          end
        end
        default: begin
          lfsr <= lfsr_step(lfsr);
          if (idx == COLS_N - 6'd1) state <= ST_IDLE;
          else                      idx   <= idx + 6'd1;
        end
      endcase
    end
  end

  // Stage p1: registered ROM address and intensity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glyph_c   <= BLANK_GLYPH;
      glyph_y   <= 4'd0;
      glyph_x   <= 3'd0;
      intensity <= INT_OFF;
      pix_valid <= 1'b0;
    end else begin
      pix_valid <= display_on;
      glyph_x   <= hpos[3:1];
      glyph_y   <= sub_p0[4:1];
      if (!display_on || col_p0 >= COLS_N || shade_p0 == INT_OFF) begin
        glyph_c   <= BLANK_GLYPH;
        intensity <= INT_OFF;
      end else begin
        glyph_c   <= glyph_of(col_p0, row_p0, e_p0);
        intensity <= shade_p0;
      end
    end
  end
endmodule
